oled_spi_monitor: RTL

Receive-side decoder for the 4-wire SPI stream the OLED driver emits (cs, sck, mosi, dc). Oversamples the pins in the fast system clock domain, reassembles MSB-first bytes, tags each with its command/data flag, and buffers them in a small FIFO behind a valid/ready handshake. Used on a loopback PMOD and in benches to check exactly what the soda machine wrote to the display, with command/data byte counters and sticky error flags.

---
 rtl/oled_spi_monitor_pkg.sv | 15 +
 rtl/oled_spi_monitor_if.sv | 11 +
 rtl/oled_spi_monitor_byte_fifo.sv | 41 ++++
 rtl/oled_spi_monitor.sv | 120 ++++++++++++
 4 files changed

// File: rtl/oled_spi_monitor_pkg.sv
// Shared types for the OLED SPI receive-side monitor.
package oled_spi_pkg;
    localparam int BYTE_W = 8;

    typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_e;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    // FIFO entry layout: dc flag above the byte.
    typedef struct packed {
        logic              dc;
        logic [BYTE_W-1:0] data;
    } spi_byte_t;
endpackage

// File: rtl/oled_spi_monitor_if.sv
// Byte stream handshake out of the monitor (show-ahead valid/ready).
interface oled_spi_monitor_if;
    import oled_spi_pkg::*;
    logic [BYTE_W-1:0] byte_data;
    logic              byte_dc;
    logic              byte_valid;
    logic              byte_ready;

    modport master (output byte_data, byte_dc, byte_valid, input byte_ready);
    modport slave  (input byte_data, byte_dc, byte_valid, output byte_ready);
endinterface

// File: rtl/oled_spi_monitor_byte_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted when a pop happens the same cycle.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/oled_spi_monitor.sv
// Oversampling SPI receiver: reassembles MSB-first bytes tagged with dc, buffers them,
// and keeps saturating command/data counters plus sticky frame/overflow flags.
module oled_spi_monitor
    import oled_spi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sck,
    input  logic                cs,
    input  logic                mosi,
    input  logic                dc,
    oled_spi_monitor_if.master  bus,
    output logic [CNT_W-1:0]    cmd_count,
    output logic [CNT_W-1:0]    data_count,
    output logic                frame_err,
    output logic                overflow,
    input  logic                clr
);
    logic [1:0]        sck_sy, cs_sy, mosi_sy, dc_sy;
    logic              sck_prev;
    logic              sck_rise;
    state_e            state;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] shreg;
    logic              done, part_err;
    spi_byte_t         done_byte, head;
    logic              fifo_full, fifo_empty, pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_sy   <= '0;
            cs_sy    <= 2'b11;
            mosi_sy  <= '0;
            dc_sy    <= '0;
            sck_prev <= 1'b0;
        end else begin
            sck_sy   <= {sck_sy[0], sck};
            cs_sy    <= {cs_sy[0], cs};
            mosi_sy  <= {mosi_sy[0], mosi};
            dc_sy    <= {dc_sy[0], dc};
            sck_prev <= sck_sy[1];
        end
    end

    assign sck_rise = sck_sy[1] && !sck_prev;

    // Completion is a one-cycle pulse; the FIFO and counters consume it on the next edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            done      <= 1'b0;
            done_byte <= '0;
            part_err  <= 1'b0;
        end else begin
            done     <= 1'b0;
            part_err <= 1'b0;
            case (state)
                IDLE: if (!cs_sy[1]) begin
                    state   <= SHIFT;
                    bit_cnt <= '0;
                end
                SHIFT: if (cs_sy[1]) begin
                    state    <= IDLE;
                    bit_cnt  <= '0;
                    part_err <= (bit_cnt != 3'd0);
                end else if (sck_rise) begin
                    shreg   <= {shreg[BYTE_W-2:0], mosi_sy[1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        done      <= 1'b1;
                        done_byte <= '{dc: dc_sy[1], data: {shreg[BYTE_W-2:0], mosi_sy[1]}};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pop = bus.byte_valid && bus.byte_ready;

    byte_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(spi_byte_t))) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (done),
        .wdata (done_byte),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.byte_data  = head.data;
    assign bus.byte_dc    = head.dc;
    assign bus.byte_valid = !fifo_empty;

    // Counters track every completed byte, even ones the FIFO had to drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_count  <= '0;
            data_count <= '0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else if (clr) begin
            cmd_count  <= '0;
            data_count <= '0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (done && done_byte.dc == DC_DATA && data_count != '1) data_count <= data_count + 1'b1;
            if (done && done_byte.dc == DC_CMD  && cmd_count  != '1) cmd_count  <= cmd_count + 1'b1;
            if (done && fifo_full && !pop) overflow  <= 1'b1;
            if (part_err)                  frame_err <= 1'b1;
        end
    end
endmodule
